// File: rtl/seg_bcd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_bcd_scan_ctrl
//
// Sequencer for a 2-digit 7-segment display. A 7-bit binary value arrives
// over a valid/ready handshake. A shift-add-3 FSM converts it to two BCD
// digits, one input bit per clock. The result is latched and the two digits
// are time-multiplexed onto the segment and digit-select pins.
//
// Parameters
//   SCAN_DIV   clk cycles per digit slot (>= 2)
//
// Ports
//   clk        in   1  system clock, all logic on posedge
//   res        in   1  synchronous, active-high reset
//   bin_in     in   7  binary value 0..127, sampled on the accept edge
//   bin_valid  in   1  source has a value to load
//   bin_ready  out  1  converter idle and able to accept a value
//   digit_seg  out  8  segments {a,b,c,d,e,f,g,dp}, active-high, registered
//   digit_con  out  2  digit select, 2'b10 = tens, 2'b01 = ones, registered
//
// Configuration macro
//   LEADING_ZERO_BLANK_EN  when defined, a zero tens digit is blanked
//                          (unless the value is out of range).
// -----------------------------------------------------------------------------
module seg_bcd_scan_ctrl #(
  parameter int SCAN_DIV = 1024
) (
  input  logic       clk,
  input  logic       res,
  input  logic [6:0] bin_in,
  input  logic       bin_valid,
  output logic       bin_ready,
  output logic [7:0] digit_seg,
  output logic [1:0] digit_con
);

  localparam int DATA_W = 7;
  localparam int PS_W   = $clog2(SCAN_DIV);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(SCAN_DIV - 1);

  localparam logic [7:0] SEG_DASH  = 8'b00000010;
  localparam logic [7:0] SEG_BLANK = 8'b00000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Conversion working set
  logic [DATA_W-1:0] bin_q;
  logic [2:0]        bit_idx;
  logic [3:0]        work_tens;
  logic [3:0]        work_ones;
  logic [7:0]        adj_word;
  logic [7:0]        work_nxt;
  logic              cur_bit;
  logic              accept;

  // Latched result
  logic [3:0]        tens_q;
  logic [3:0]        ones_q;
  logic              ovf_q;

  // Scan timing
  logic [PS_W-1:0]   prescaler;
  logic              scan_tick;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Double-dabble correction: a nibble of 5 or more would exceed 9 after the
  // doubling shift, so add 3 beforehand to carry into the next digit.
  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Seven-segment encoding of one BCD digit. Codes above 9 cannot occur for
  // in-range values; they show a dash so a fault is visible on the glass.
  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 8'b11111100;
      4'd1:    seg_encode = 8'b01100000;
      4'd2:    seg_encode = 8'b11011010;
      4'd3:    seg_encode = 8'b11110010;
      4'd4:    seg_encode = 8'b01100110;
      4'd5:    seg_encode = 8'b10110110;
      4'd6:    seg_encode = 8'b10111110;
      4'd7:    seg_encode = 8'b11100000;
      4'd8:    seg_encode = 8'b11111110;
      4'd9:    seg_encode = 8'b11110110;
      default: seg_encode = SEG_DASH;
    endcase
  endfunction

  // Pattern for one display slot, including the out-of-range dash and the
  // optional leading-zero blanking of the tens slot.
  function automatic logic [7:0] slot_pattern(input logic       tens_sel,
                                              input logic [3:0] tens,
                                              input logic [3:0] ones,
                                              input logic       ovf);
    if (ovf) begin
      slot_pattern = SEG_DASH;
    end else if (tens_sel) begin
`ifdef LEADING_ZERO_BLANK_EN
      slot_pattern = (tens == 4'd0) ? SEG_BLANK : seg_encode(tens);
`else
      slot_pattern = seg_encode(tens);
`endif
    end else begin
      slot_pattern = seg_encode(ones);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bin_valid) state_nxt = SHIFT;
      SHIFT:   if (bit_idx == 3'd0) state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bin_ready = (state == IDLE);
    accept    = (state == IDLE) && bin_valid;
  end

  // ---------------------------------------------------------------------------
  // Shift-add-3 step: correct both nibbles, then shift the current bit in.
  // The tens carry out is dropped; values above 99 are flagged by ovf_q.
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_bit  = bin_q[bit_idx];
    adj_word = {add3(work_tens), add3(work_ones)};
    work_nxt = (adj_word << 1) | {7'd0, cur_bit};
  end

  // Working registers carry no reset: they are fully reloaded on every accept
  // and are only consumed while the FSM is in SHIFT or LATCH.
  always_ff @(posedge clk) begin
    if (accept) begin
      bin_q     <= bin_in;
      bit_idx   <= 3'd6;
      work_tens <= 4'd0;
      work_ones <= 4'd0;
    end else if (state == SHIFT) begin
      {work_tens, work_ones} <= work_nxt;
      bit_idx                <= bit_idx - 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Result latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (res) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      ovf_q  <= 1'b0;
    end else if (state == LATCH) begin
      tens_q <= work_tens;
      ones_q <= work_ones;
      ovf_q  <= (bin_q > 7'd99);
    end
  end

  // ---------------------------------------------------------------------------
  // Scan prescaler
  // ---------------------------------------------------------------------------
  assign scan_tick = (prescaler == PS_MAX);

  always_ff @(posedge clk) begin
    if (res) begin
      prescaler <= '0;
    end else if (scan_tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PS_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Digit multiplexer. Select and pattern update on the same edge; the pattern
  // is that of the slot becoming active (tens when leaving the ones slot).
  // A tick coinciding with LATCH still sees the previous tens_q/ones_q.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (res) begin
      digit_con <= 2'b01;
      digit_seg <= 8'b11111100;
    end else if (scan_tick) begin
      digit_con <= {digit_con[0], digit_con[1]};
      digit_seg <= slot_pattern(digit_con[0], tens_q, ones_q, ovf_q);
    end
  end

endmodule

// File: tb/tb_seg_bcd_scan_ctrl.sv
module tb_seg_bcd_scan_ctrl;

  localparam int SD = 4;

  logic       clk;
  logic       res;
  logic [6:0] bin_in;
  logic       bin_valid;
  logic       bin_ready;
  logic [7:0] digit_seg;
  logic [1:0] digit_con;

  int checks   = 0;
  int failures = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] EXP_TENS_ZERO = 8'b00000000;
`else
  localparam logic [7:0] EXP_TENS_ZERO = 8'b11111100;
`endif

  seg_bcd_scan_ctrl #(.SCAN_DIV(SD)) dut (
    .clk       (clk),
    .res       (res),
    .bin_in    (bin_in),
    .bin_valid (bin_valid),
    .bin_ready (bin_ready),
    .digit_seg (digit_seg),
    .digit_con (digit_con)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer a value, wait for acceptance, then count cycles with ready low.
  // Called and returns at a negedge; busy is 50 on timeout.
  task automatic do_load(input logic [6:0] v, output int busy);
    int guard;
    bin_in    = v;
    bin_valid = 1'b1;
    guard     = 0;
    while (!bin_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    bin_valid = 1'b0;
    busy = 0;
    while (!bin_ready && busy < 50) begin
      busy++;
      @(negedge clk);
    end
  endtask

  // Observe the next two scan slots and return the pattern seen in each.
  task automatic read_display(output logic [7:0] t, output logic [7:0] o);
    logic [1:0] c0;
    int g;
    t = 'x;
    o = 'x;
    for (int s = 0; s < 2; s++) begin
      c0 = digit_con;
      g  = 0;
      while (digit_con === c0 && g < 4 * SD) begin
        @(negedge clk);
        g++;
      end
      if (digit_con === 2'b10) t = digit_seg;
      else if (digit_con === 2'b01) o = digit_seg;
    end
  endtask

  task automatic test_reset;
    logic [1:0] exp_con;
    res       = 1'b1;
    bin_valid = 1'b0;
    bin_in    = 7'd0;
    repeat (2) @(negedge clk);
    res = 1'b0;
    checks++;
    if (bin_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b exp=1", bin_ready);
    end
    checks++;
    if (digit_con !== 2'b01) begin
      failures++; $display("FAIL reset_con got=%b exp=01", digit_con);
    end
    checks++;
    if (digit_seg !== 8'b11111100) begin
      failures++; $display("FAIL reset_seg got=%b exp=11111100", digit_seg);
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_con = (((k / 4) % 2) == 1) ? 2'b10 : 2'b01;
      checks++;
      if (digit_con !== exp_con || digit_seg !== 8'b11111100) begin
        failures++;
        $display("FAIL scan_toggle k=%0d got con=%b seg=%b exp con=%b seg=11111100",
                 k, digit_con, digit_seg, exp_con);
      end
    end
  endtask

  task automatic test_load42;
    int busy;
    logic [7:0] t, o;
    do_load(7'd42, busy);
    checks++;
    if (busy !== 8) begin
      failures++; $display("FAIL load42_busy got=%0d exp=8", busy);
    end
    read_display(t, o);
    checks++;
    if (t !== 8'b01100110) begin
      failures++; $display("FAIL load42_tens got=%b exp=01100110", t);
    end
    checks++;
    if (o !== 8'b11011010) begin
      failures++; $display("FAIL load42_ones got=%b exp=11011010", o);
    end
  endtask

  task automatic test_boundary;
    int busy;
    logic [7:0] t, o;
    logic [6:0] vals [4];
    logic [7:0] exp_t [4];
    logic [7:0] exp_o [4];
    vals[0] = 7'd99;  exp_t[0] = 8'b11110110; exp_o[0] = 8'b11110110;
    vals[1] = 7'd100; exp_t[1] = 8'b00000010; exp_o[1] = 8'b00000010;
    vals[2] = 7'd127; exp_t[2] = 8'b00000010; exp_o[2] = 8'b00000010;
    vals[3] = 7'd0;   exp_t[3] = EXP_TENS_ZERO; exp_o[3] = 8'b11111100;
    for (int i = 0; i < 4; i++) begin
      do_load(vals[i], busy);
      read_display(t, o);
      checks++;
      if (t !== exp_t[i] || o !== exp_o[i]) begin
        failures++;
        $display("FAIL boundary_%0d got tens=%b ones=%b exp tens=%b ones=%b",
                 vals[i], t, o, exp_t[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int busy;
    logic [7:0] t, o;
    bin_in    = 7'd13;
    bin_valid = 1'b1;
    @(negedge clk);
    bin_in = 7'd55;
    busy = 0;
    while (!bin_ready && busy < 50) begin
      busy++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 8) begin
      failures++; $display("FAIL b2b_busy13 got=%0d exp=8", busy);
    end
    @(negedge clk);
    bin_valid = 1'b0;
    checks++;
    if (bin_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_accept55 got ready=%b exp=0", bin_ready);
    end
    read_display(t, o);
    checks++;
    if (t !== 8'b01100000 || o !== 8'b11110010) begin
      failures++;
      $display("FAIL b2b_show13 got tens=%b ones=%b exp tens=01100000 ones=11110010", t, o);
    end
    busy = 0;
    while (!bin_ready && busy < 50) begin
      busy++;
      @(negedge clk);
    end
    read_display(t, o);
    checks++;
    if (t !== 8'b10110110 || o !== 8'b10110110) begin
      failures++;
      $display("FAIL b2b_show55 got tens=%b ones=%b exp tens=10110110 ones=10110110", t, o);
    end
  endtask

  task automatic test_reset_abort;
    logic [7:0] t, o;
    bin_in    = 7'd88;
    bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    checks++;
    if (bin_ready !== 1'b0) begin
      failures++; $display("FAIL abort_accept got ready=%b exp=0", bin_ready);
    end
    repeat (3) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    checks++;
    if (bin_ready !== 1'b1 || digit_con !== 2'b01 || digit_seg !== 8'b11111100) begin
      failures++;
      $display("FAIL abort_reset got ready=%b con=%b seg=%b exp ready=1 con=01 seg=11111100",
               bin_ready, digit_con, digit_seg);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (bin_ready !== 1'b1) begin
      failures++; $display("FAIL abort_stays_idle got ready=%b exp=1", bin_ready);
    end
    for (int r = 0; r < 2; r++) begin
      read_display(t, o);
      checks++;
      if (t !== EXP_TENS_ZERO || o !== 8'b11111100) begin
        failures++;
        $display("FAIL abort_show00 got tens=%b ones=%b exp tens=%b ones=11111100",
                 t, o, EXP_TENS_ZERO);
      end
    end
  endtask

  task automatic test_leading_zero;
    int busy;
    logic [7:0] t, o;
    do_load(7'd7, busy);
    read_display(t, o);
    checks++;
    if (t !== EXP_TENS_ZERO) begin
      failures++; $display("FAIL lz_tens got=%b exp=%b", t, EXP_TENS_ZERO);
    end
    checks++;
    if (o !== 8'b11100000) begin
      failures++; $display("FAIL lz_ones got=%b exp=11100000", o);
    end
  endtask

  initial begin
    res       = 1'b1;
    bin_valid = 1'b0;
    bin_in    = 7'd0;
    test_reset();
    test_load42();
    test_boundary();
    test_back_to_back();
    test_reset_abort();
    test_leading_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
